// File: rtl/isq_pkg.sv
// isq_pkg -- shared types for the integer issue queue.
//   isq_entry_t   : one queue slot (valid, payload, robid, source tags, source ready bits).
//                   Fields are sized to the widest supported configuration; narrower
//                   instances zero-extend into them.
//   robid_younger : wrap-aware ROB id age compare, MSB of the id is the wrap bit.
// Also supplies a default for INSTR_ID_WIDTH when the build does not define it.

`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 5
`endif

package isq_pkg;

  localparam int ISQ_DATA_W_MAX  = 128;
  localparam int ISQ_PREG_W_MAX  = 8;
  localparam int ISQ_ROBID_W_MAX = 16;

  typedef struct packed {
    logic                       valid;
    logic [ISQ_DATA_W_MAX-1:0]  data;
    logic [ISQ_ROBID_W_MAX-1:0] robid;
    logic [ISQ_PREG_W_MAX-1:0]  prs1;
    logic [ISQ_PREG_W_MAX-1:0]  prs2;
    logic                       src1_rdy;
    logic                       src2_rdy;
  } isq_entry_t;

  // True when a is strictly younger than b for a w-bit id (w >= 2).
  // Same wrap bit: larger low bits are younger. Different wrap bit: smaller low bits are younger.
  function automatic logic robid_younger(input logic [ISQ_ROBID_W_MAX-1:0] a,
                                         input logic [ISQ_ROBID_W_MAX-1:0] b,
                                         input int unsigned                w);
    logic [ISQ_ROBID_W_MAX-1:0] msb_mask;
    logic [ISQ_ROBID_W_MAX-1:0] low_mask;
    logic                       a_wrap;
    logic                       b_wrap;
    msb_mask = ISQ_ROBID_W_MAX'(1) << (w - 1);
    low_mask = msb_mask - ISQ_ROBID_W_MAX'(1);
    a_wrap   = |(a & msb_mask);
    b_wrap   = |(b & msb_mask);
    if (a_wrap == b_wrap) return (a & low_mask) > (b & low_mask);
    else                  return (a & low_mask) < (b & low_mask);
  endfunction

endpackage

// File: rtl/isq_age_matrix.sv
// isq_age_matrix -- enqueue-order tracker for the issue queue.
//   clock, reset_n : clock, asynchronous active-high reset
//   alloc_oh       : one-hot slot being allocated this cycle
//   free_vec       : slots being released this cycle (issue or squash)
//   older_vec      : slots currently holding an entry
//   req            : request vector (eligible slots)
//   grant_oh       : one-hot oldest requesting slot, zero when req is zero
// Row i holds the set of live slots that were allocated before slot i.

module isq_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_vec,
  input  logic [DEPTH-1:0] older_vec,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant_oh
);

  logic [DEPTH-1:0] older_q [DEPTH];

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) older_q[i] <= older_vec & ~free_vec;
        else             older_q[i] <= older_q[i] & ~free_vec;
      end
    end
  end

  // A requester wins when no older live slot is also requesting.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      grant_oh[i] = req[i] && ((older_q[i] & req) == '0);
  end

endmodule

// File: rtl/int_isq_age_wakeup.sv
// int_isq_age_wakeup -- integer issue queue with tag wakeup and age-ordered select.
//   clock, reset_n            : clock, asynchronous reset (active HIGH despite the name)
//   enq_*                     : enqueue handshake, payload, robid, source tags and ready bits
//   deq_*                     : issue handshake; data/robid are combinational from the selected slot
//   wb_valid/wb_need_to_wb/wb_prd : NUM_WB writeback wakeup ports
//   flush_valid/flush_robid   : squash every entry strictly younger than flush_robid
//   occupancy                 : registered count of valid entries
// Build option: ISQ_ENQ_WAKEUP_BYPASS_EN -- when defined, an enqueuing source whose tag
// matches a same-cycle qualified writeback is stored ready.

module int_isq_age_wakeup
  import isq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_WB  = 2,
  parameter int DATA_W  = 128,
  parameter int PREG_W  = 6,
  parameter int ROBID_W = `INSTR_ID_WIDTH + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [DATA_W-1:0]        enq_data,
  input  logic [ROBID_W-1:0]       enq_robid,
  input  logic [PREG_W-1:0]        enq_prs1,
  input  logic [PREG_W-1:0]        enq_prs2,
  input  logic                     enq_src1_rdy,
  input  logic                     enq_src2_rdy,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [DATA_W-1:0]        deq_data,
  output logic [ROBID_W-1:0]       deq_robid,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB-1:0]        wb_need_to_wb,
  input  logic [NUM_WB*PREG_W-1:0] wb_prd,
  input  logic                     flush_valid,
  input  logic [ROBID_W-1:0]       flush_robid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  isq_entry_t       ent_q   [DEPTH];
  isq_entry_t       ent_nxt [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;
  logic [DEPTH-1:0] valid_vec, elig_vec, grant_oh, free_oh, alloc_oh, free_vec, flush_vec;
  logic [NUM_WB-1:0] wb_qual;
  logic [IDX_W-1:0] sel_idx;
  logic             enq_fire, deq_fire;

  assign wb_qual   = wb_valid & wb_need_to_wb;
  assign occupancy = occ_q;
  assign enq_ready = occ_q < OCC_W'(DEPTH);
  assign deq_valid = (|elig_vec) && !flush_valid;
  assign enq_fire  = enq_valid && enq_ready && !flush_valid;
  assign deq_fire  = deq_valid && deq_ready;

  always_comb begin
    valid_vec = '0;
    elig_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      elig_vec[i]  = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
    end
  end

  // Lowest-index free slot: scan downward so the lowest hit is written last.
  always_comb begin
    free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_vec[i]) free_oh = DEPTH'(1) << i;
  end
  assign alloc_oh = enq_fire ? free_oh : '0;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant_oh[i]) sel_idx = IDX_W'(i);
  end
  assign deq_data  = ent_q[sel_idx].data[DATA_W-1:0];
  assign deq_robid = ent_q[sel_idx].robid[ROBID_W-1:0];

`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
  logic enq_hit1, enq_hit2;
  always_comb begin
    enq_hit1 = 1'b0;
    enq_hit2 = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_qual[k] && (wb_prd[k*PREG_W +: PREG_W] == enq_prs1)) enq_hit1 = 1'b1;
      if (wb_qual[k] && (wb_prd[k*PREG_W +: PREG_W] == enq_prs2)) enq_hit2 = 1'b1;
    end
  end
`endif

  always_comb begin
    flush_vec = '0;
    free_vec  = '0;
    occ_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent_q[i];
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_qual[k]) begin
          if (ent_q[i].prs1 == ISQ_PREG_W_MAX'(wb_prd[k*PREG_W +: PREG_W])) ent_nxt[i].src1_rdy = 1'b1;
          if (ent_q[i].prs2 == ISQ_PREG_W_MAX'(wb_prd[k*PREG_W +: PREG_W])) ent_nxt[i].src2_rdy = 1'b1;
        end
      end
      flush_vec[i] = flush_valid && ent_q[i].valid &&
                     robid_younger(ent_q[i].robid, ISQ_ROBID_W_MAX'(flush_robid), ROBID_W);
      free_vec[i]  = flush_vec[i] || (deq_fire && grant_oh[i]);
      if (free_vec[i]) ent_nxt[i].valid = 1'b0;
      if (alloc_oh[i]) begin
        ent_nxt[i]       = '0;
        ent_nxt[i].valid = 1'b1;
        ent_nxt[i].data  = ISQ_DATA_W_MAX'(enq_data);
        ent_nxt[i].robid = ISQ_ROBID_W_MAX'(enq_robid);
        ent_nxt[i].prs1  = ISQ_PREG_W_MAX'(enq_prs1);
        ent_nxt[i].prs2  = ISQ_PREG_W_MAX'(enq_prs2);
`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
        ent_nxt[i].src1_rdy = enq_src1_rdy || enq_hit1;
        ent_nxt[i].src2_rdy = enq_src2_rdy || enq_hit2;
`else
        ent_nxt[i].src1_rdy = enq_src1_rdy;
        ent_nxt[i].src2_rdy = enq_src2_rdy;
`endif
      end
      occ_nxt = occ_nxt + OCC_W'(ent_nxt[i].valid);
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_nxt[i];
      occ_q <= occ_nxt;
    end
  end

  isq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock     (clock),
    .reset_n   (reset_n),
    .alloc_oh  (alloc_oh),
    .free_vec  (free_vec),
    .older_vec (valid_vec),
    .req       (elig_vec),
    .grant_oh  (grant_oh)
  );

endmodule

// File: tb/tb_int_isq_age_wakeup.sv
// tb_int_isq_age_wakeup -- directed scenarios plus random traffic for int_isq_age_wakeup,
// checked against a slot-array model that orders entries by an enqueue sequence number.

module tb_int_isq_age_wakeup;

  localparam int DEPTH = 8, NUM_WB = 2, DATA_W = 128, PREG_W = 6, ROBID_W = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic enq_valid, enq_ready, enq_src1_rdy, enq_src2_rdy;
  logic [DATA_W-1:0] enq_data, deq_data;
  logic [ROBID_W-1:0] enq_robid, deq_robid, flush_robid;
  logic [PREG_W-1:0] enq_prs1, enq_prs2;
  logic deq_valid, deq_ready, flush_valid;
  logic [NUM_WB-1:0] wb_valid, wb_need_to_wb;
  logic [NUM_WB*PREG_W-1:0] wb_prd;
  logic [3:0] occupancy;

  int n_chk = 0;
  int n_err = 0;

  // model state
  bit          m_v   [DEPTH];
  int          m_seq [DEPTH];
  logic [5:0]  m_rob [DEPTH];
  logic [127:0] m_data [DEPTH];
  logic [5:0]  m_p1  [DEPTH];
  logic [5:0]  m_p2  [DEPTH];
  bit          m_r1  [DEPTH];
  bit          m_r2  [DEPTH];
  int          seq_ctr = 0;

  int_isq_age_wakeup #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
                       .PREG_W(PREG_W), .ROBID_W(ROBID_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_robid(enq_robid), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_robid(deq_robid),
    .wb_valid(wb_valid), .wb_need_to_wb(wb_need_to_wb), .wb_prd(wb_prd),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit younger(input logic [5:0] a, input logic [5:0] b);
    if (a[5] == b[5]) return a[4:0] > b[4:0];
    return a[4:0] < b[4:0];
  endfunction

  function automatic bit woken(input logic [5:0] tag);
    for (int k = 0; k < NUM_WB; k++)
      if (wb_valid[k] && wb_need_to_wb[k] && wb_prd[k*PREG_W +: PREG_W] == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    enq_valid = 0; enq_data = '0; enq_robid = '0; enq_prs1 = '0; enq_prs2 = '0;
    enq_src1_rdy = 0; enq_src2_rdy = 0; deq_ready = 0;
    wb_valid = '0; wb_need_to_wb = '0; wb_prd = '0; flush_valid = 0; flush_robid = '0;
  endtask

  // Called at a falling edge with inputs set: check outputs, advance model, cross one rising edge.
  task automatic step();
    int sel, cnt, free;
    bit exp_dv;
    #1;
    sel = -1; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i]) cnt++;
      if (m_v[i] && m_r1[i] && m_r2[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
    end
    exp_dv = (sel >= 0) && !flush_valid;
    chk("occupancy", occupancy, cnt);
    chk("enq_ready", enq_ready, cnt < DEPTH);
    chk("deq_valid", deq_valid, exp_dv);
    if (exp_dv) begin
      chk("deq_robid", deq_robid, m_rob[sel]);
      chk("deq_data", deq_data, m_data[sel]);
    end
    free = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) free = i;
    if (flush_valid)
      for (int i = 0; i < DEPTH; i++) if (m_v[i] && younger(m_rob[i], flush_robid)) m_v[i] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (woken(m_p1[i])) m_r1[i] = 1;
      if (woken(m_p2[i])) m_r2[i] = 1;
    end
    if (!flush_valid) begin
      if (exp_dv && deq_ready) m_v[sel] = 0;
      if (enq_valid && cnt < DEPTH) begin
        m_v[free] = 1; m_seq[free] = seq_ctr++; m_rob[free] = enq_robid;
        m_data[free] = enq_data; m_p1[free] = enq_prs1; m_p2[free] = enq_prs2;
        m_r1[free] = enq_src1_rdy; m_r2[free] = enq_src2_rdy;
`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
        if (woken(enq_prs1)) m_r1[free] = 1;
        if (woken(enq_prs2)) m_r2[free] = 1;
`endif
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic enq_one(input logic [5:0] rob, input logic [5:0] p1, input logic [5:0] p2,
                         input bit r1, input bit r2);
    enq_valid = 1; enq_robid = rob; enq_prs1 = p1; enq_prs2 = p2;
    enq_src1_rdy = r1; enq_src2_rdy = r2; enq_data = {4{$urandom}};
    step();
    enq_valid = 0;
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    reset_n = 1; #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_enq_ready", enq_ready, 1);
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 0;
  endtask

  task automatic drain();
    idle(); deq_ready = 1;
    for (int n = 0; n < 20 && occupancy != 0; n++) step();
    chk("drain_empty", occupancy, 0);
    idle();
  endtask

  initial begin
    idle();
    @(negedge clock);
    do_reset();

    // in-order issue of three ready entries
    for (int j = 1; j <= 3; j++) enq_one(6'(j), 6'(j), 6'(j), 1, 1);
    deq_ready = 1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("order_occ", occupancy, 3 - j);
      chk("order_robid", deq_robid, j + 1);
      step();
    end
    #1; chk("order_empty_dv", deq_valid, 0);
    idle();

    // wakeup of an older blocked entry
    enq_one(6'h04, 6'd5, 6'd2, 0, 1);
    enq_one(6'h05, 6'd1, 6'd2, 1, 1);
    wb_valid = 2'b10; wb_need_to_wb = 2'b10; wb_prd = {6'd5, 6'd0}; deq_ready = 1;
    #1; chk("wake_first_robid", deq_robid, 6'h05);
    step();
    wb_valid = '0; wb_need_to_wb = '0;
    #1; chk("wake_next_dv", deq_valid, 1); chk("wake_next_robid", deq_robid, 6'h04);
    step();
    idle();

    // full queue, then simultaneous enq and deq
    for (int j = 0; j < DEPTH; j++) enq_one(6'(j), 6'd1, 6'd1, 1, 1);
    #1; chk("full_enq_ready", enq_ready, 0); chk("full_occ", occupancy, 8);
    enq_valid = 1; enq_robid = 6'h30; step();
    enq_valid = 0; deq_ready = 1; step();
    #1; chk("one_deq_occ", occupancy, 7);
    enq_valid = 1; enq_robid = 6'h31; enq_src1_rdy = 1; enq_src2_rdy = 1; step();
    #1; chk("enq_deq_occ", occupancy, 7);
    deq_ready = 0; step();
    #1; chk("refill_occ", occupancy, 8);
    drain();

    // wrap-aware flush
    enq_one(6'h1E, 6'd1, 6'd1, 1, 1);
    enq_one(6'h1F, 6'd1, 6'd1, 1, 1);
    enq_one(6'h20, 6'd1, 6'd1, 1, 1);
    flush_valid = 1; flush_robid = 6'h1F; deq_ready = 1;
    enq_valid = 1; enq_robid = 6'h07; enq_src1_rdy = 1; enq_src2_rdy = 1;
    #1; chk("flush_dv", deq_valid, 0);
    step();
    idle();
    #1; chk("flush_occ", occupancy, 2);
    drain();

    // two ports wake both sources of one entry; unqualified writeback is ignored
    enq_one(6'h07, 6'd10, 6'd11, 0, 0);
    wb_valid = 2'b11; wb_need_to_wb = 2'b00; wb_prd = {6'd11, 6'd10}; step();
    #1; chk("noneed_dv", deq_valid, 0);
    wb_need_to_wb = 2'b11; step();
    wb_valid = '0; wb_need_to_wb = '0;
    #1; chk("dual_wake_dv", deq_valid, 1); chk("dual_wake_robid", deq_robid, 6'h07);
    drain();

    // reset with entries in flight
    for (int j = 0; j < 5; j++) enq_one(6'(j + 8), 6'd0, 6'd0, 0, 0);
    enq_valid = 1; enq_robid = 6'h15;
    do_reset();
    idle(); step();
    chk("post_rst_occ", occupancy, 0);

`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
    wb_valid = 2'b01; wb_need_to_wb = 2'b01; wb_prd = {6'd0, 6'd9};
    enq_one(6'h03, 6'd1, 6'd9, 1, 0);
    idle();
    #1; chk("bypass_dv", deq_valid, 1); chk("bypass_robid", deq_robid, 6'h03);
    drain();
`endif

    // random traffic
    for (int c = 0; c < 600; c++) begin
      enq_valid     = ($urandom_range(0, 9) < 7);
      enq_data      = {4{$urandom}};
      enq_robid     = 6'($urandom);
      enq_prs1      = 6'($urandom_range(0, 7));
      enq_prs2      = 6'($urandom_range(0, 7));
      enq_src1_rdy  = 1'($urandom);
      enq_src2_rdy  = 1'($urandom);
      deq_ready     = ($urandom_range(0, 9) < 6);
      wb_valid      = 2'($urandom);
      wb_need_to_wb = 2'($urandom) | 2'($urandom);
      wb_prd        = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      flush_valid   = ($urandom_range(0, 9) == 0);
      flush_robid   = 6'($urandom);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
